// File: rtl/pipe_reg.sv
// pipe_reg: generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Latches a payload and valid bit, honours hold for at most HOLD_MAX consecutive
// edges (0 = unlimited), inserts a bubble on flush and counts stalled edges.
module pipe_reg #(
    parameter int               WIDTH     = 64,
    parameter int               HOLD_MAX  = 1,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             hold,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             held,
    output logic             forced,
    output logic [15:0]      stall_total
);

    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] HCNT_SAT  = '1;
    localparam logic [15:0]      STALL_SAT = 16'hFFFF;

    logic [WIDTH-1:0] data_reg, data_next;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] hcnt_reg, hcnt_next;
    logic             held_reg, held_next;
    logic             forced_reg, forced_next;
    logic [15:0]      stall_reg, stall_next;
    logic             hold_ok;

    // A hold is honoured while the consecutive-hold budget is not exhausted.
    always_comb begin
        hold_ok = hold && ((HOLD_MAX == 0) || (hcnt_reg < HOLD_LIM));
    end

    // Next-state selection in priority order: flush, honoured hold, advance.
    always_comb begin
        data_next   = data_reg;
        valid_next  = valid_reg;
        hcnt_next   = hcnt_reg;
        held_next   = 1'b0;
        forced_next = 1'b0;
        stall_next  = stall_reg;
        if (flush) begin
            // Bubble; a squashed edge is not a stall, so stall_total is untouched.
            data_next  = NOP_VALUE;
            valid_next = 1'b0;
            hcnt_next  = '0;
        end else if (hold_ok) begin
            held_next = 1'b1;
            // Saturate so the unlimited (HOLD_MAX == 0) case never wraps.
            if (hcnt_reg != HCNT_SAT) begin
                hcnt_next = hcnt_reg + CNT_W'(1);
            end
            if (stall_reg != STALL_SAT) begin
                stall_next = stall_reg + 16'd1;
            end
        end else begin
            // Advance; if hold was still requested this is a forced advance.
            data_next   = in_data;
            valid_next  = in_valid;
            hcnt_next   = '0;
            forced_next = hold;
        end
    end

    // State registers with synchronous active-low reset; reset outranks flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg   <= NOP_VALUE;
            valid_reg  <= 1'b0;
            hcnt_reg   <= '0;
            held_reg   <= 1'b0;
            forced_reg <= 1'b0;
            stall_reg  <= 16'd0;
        end else begin
            data_reg   <= data_next;
            valid_reg  <= valid_next;
            hcnt_reg   <= hcnt_next;
            held_reg   <= held_next;
            forced_reg <= forced_next;
            stall_reg  <= stall_next;
        end
    end

    assign out_data    = data_reg;
    assign out_valid   = valid_reg;
    assign held        = held_reg;
    assign forced      = forced_reg;
    assign stall_total = stall_reg;

endmodule

// File: tb/tb_pipe_reg.sv
// Directed testbench for pipe_reg: three instances (HOLD_MAX = 1, 3, 0) share
// the same stimulus; each scenario task checks the instance it targets.
module tb_pipe_reg;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, hold, flush;
    logic [W-1:0] in_data;

    logic [W-1:0] d1, d3, d0;
    logic         v1, v3, v0, h1, h3, h0, f1, f3, f0;
    logic [15:0]  s1, s3, s0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_reg #(.WIDTH(W), .HOLD_MAX(1), .NOP_VALUE('0), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .hold(hold), .flush(flush), .out_data(d1), .out_valid(v1),
        .held(h1), .forced(f1), .stall_total(s1));

    pipe_reg #(.WIDTH(W), .HOLD_MAX(3), .NOP_VALUE('0), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .hold(hold), .flush(flush), .out_data(d3), .out_valid(v3),
        .held(h3), .forced(f3), .stall_total(s3));

    pipe_reg #(.WIDTH(W), .HOLD_MAX(0), .NOP_VALUE('0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .hold(hold), .flush(flush), .out_data(d0), .out_valid(v0),
        .held(h0), .forced(f0), .stall_total(s0));

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0; in_valid = 1'b1;
        in_data = 64'hDEAD_BEEF_0000_0004;
        tick();
        tick();
        $display("reset: d1=%h v1=%b held=%b forced=%b stall=%0d", d1, v1, h1, f1, s1);
        checks++; if (d1 !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", d1); end
        checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", v1); end
        checks++; if (h1 !== 1'b0 || f1 !== 1'b0) begin failures++; $display("FAIL reset_flags held=%b forced=%b exp=0,0", h1, f1); end
        checks++; if (s1 !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", s1); end
        checks++; if (d3 !== 64'd0 || d0 !== 64'd0) begin failures++; $display("FAIL reset_data_others d3=%h d0=%h exp=0", d3, d0); end
    endtask

    task automatic test_pipelining();
        logic [W-1:0] vals [3];
        vals[0] = 64'd1; vals[1] = 64'd2; vals[2] = 64'd3;
        rst_n = 1'b1; hold = 1'b0; flush = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vals[i];
            tick();
            $display("pipe: in=%0d out=%0d valid=%b", vals[i], d1, v1);
            checks++; if (d1 !== vals[i] || v1 !== 1'b1) begin
                failures++; $display("FAIL pipe_%0d got=%h/%b exp=%h/1", i, d1, v1, vals[i]);
            end
        end
        checks++; if (h1 !== 1'b0 || f1 !== 1'b0) begin failures++; $display("FAIL pipe_flags held=%b forced=%b exp=0,0", h1, f1); end
    endtask

    task automatic test_legacy_hold1();
        logic [W-1:0] exp_d [4];
        logic         exp_h [4];
        exp_d[0] = 64'd5; exp_d[1] = 64'd7; exp_d[2] = 64'd7; exp_d[3] = 64'd9;
        exp_h[0] = 1'b1;  exp_h[1] = 1'b0;  exp_h[2] = 1'b1;  exp_h[3] = 1'b0;
        do_reset();
        in_valid = 1'b1; in_data = 64'd5; tick();
        checks++; if (d1 !== 64'd5) begin failures++; $display("FAIL legacy_load got=%h exp=5", d1); end
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 64'(6 + i);
            tick();
            $display("legacy: in=%0d out=%0d held=%b forced=%b", 6 + i, d1, h1, f1);
            checks++; if (d1 !== exp_d[i] || h1 !== exp_h[i] || f1 !== !exp_h[i]) begin
                failures++;
                $display("FAIL legacy_%0d got d=%h held=%b forced=%b exp d=%h held=%b forced=%b",
                         i, d1, h1, f1, exp_d[i], exp_h[i], !exp_h[i]);
            end
        end
        checks++; if (s1 !== 16'd2) begin failures++; $display("FAIL legacy_stall got=%0d exp=2", s1); end
        hold = 1'b0;
    endtask

    task automatic test_bounded_hold3();
        do_reset();
        in_valid = 1'b1; in_data = 64'hA; tick();
        hold = 1'b1; in_data = 64'hB;
        for (int i = 1; i <= 3; i++) begin
            tick();
            $display("bounded: edge=%0d out=%h held=%b stall=%0d", i, d3, h3, s3);
            checks++; if (d3 !== 64'hA || h3 !== 1'b1 || f3 !== 1'b0 || s3 !== 16'(i)) begin
                failures++;
                $display("FAIL bounded_hold_%0d got d=%h held=%b forced=%b stall=%0d exp d=a held=1 forced=0 stall=%0d",
                         i, d3, h3, f3, s3, i);
            end
        end
        tick();
        $display("bounded: edge=4 out=%h forced=%b stall=%0d", d3, f3, s3);
        checks++; if (d3 !== 64'hB || h3 !== 1'b0 || f3 !== 1'b1 || s3 !== 16'd3) begin
            failures++; $display("FAIL bounded_force got d=%h held=%b forced=%b stall=%0d exp d=b held=0 forced=1 stall=3", d3, h3, f3, s3);
        end
        tick();
        $display("bounded: edge=5 out=%h held=%b stall=%0d", d3, h3, s3);
        checks++; if (d3 !== 64'hB || h3 !== 1'b1 || f3 !== 1'b0 || s3 !== 16'd4) begin
            failures++; $display("FAIL bounded_rehold got d=%h held=%b forced=%b stall=%0d exp d=b held=1 forced=0 stall=4", d3, h3, f3, s3);
        end
        hold = 1'b0;
    endtask

    task automatic test_flush_priority();
        do_reset();
        in_valid = 1'b1; in_data = 64'h10; tick();
        hold = 1'b1; in_data = 64'h99; tick();
        checks++; if (d3 !== 64'h10 || s3 !== 16'd1 || h3 !== 1'b1) begin
            failures++; $display("FAIL flush_prehold got d=%h stall=%0d held=%b exp d=10 stall=1 held=1", d3, s3, h3);
        end
        flush = 1'b1; tick();
        $display("flush: out=%h valid=%b held=%b stall=%0d", d3, v3, h3, s3);
        checks++; if (d3 !== 64'd0 || v3 !== 1'b0 || h3 !== 1'b0 || f3 !== 1'b0) begin
            failures++; $display("FAIL flush_bubble got d=%h v=%b held=%b forced=%b exp 0/0/0/0", d3, v3, h3, f3);
        end
        checks++; if (s3 !== 16'd1) begin failures++; $display("FAIL flush_stall got=%0d exp=1", s3); end
        flush = 1'b0; hold = 1'b0; in_data = 64'h20; tick();
        $display("flush: next out=%h valid=%b", d3, v3);
        checks++; if (d3 !== 64'h20 || v3 !== 1'b1) begin failures++; $display("FAIL flush_resume got=%h/%b exp=20/1", d3, v3); end
        // Reset together with flush: reset wins and clears stall_total.
        hold = 1'b1; tick();
        rst_n = 1'b0; flush = 1'b1; tick();
        $display("reset+flush: out=%h stall=%0d", d3, s3);
        checks++; if (s3 !== 16'd0 || d3 !== 64'd0 || v3 !== 1'b0) begin
            failures++; $display("FAIL reset_flush got d=%h v=%b stall=%0d exp 0/0/0", d3, v3, s3);
        end
        rst_n = 1'b1; flush = 1'b0; hold = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        in_valid = 1'b1; in_data = 64'h30; tick();
        hold = 1'b1; tick(); tick();
        checks++; if (s3 !== 16'd2 || h3 !== 1'b1) begin failures++; $display("FAIL midrst_pre stall=%0d held=%b exp 2/1", s3, h3); end
        rst_n = 1'b0; tick();
        rst_n = 1'b1; in_data = 64'h40;
        for (int i = 1; i <= 3; i++) begin
            tick();
            $display("midrst: edge=%0d out=%h held=%b stall=%0d", i, d3, h3, s3);
            checks++; if (h3 !== 1'b1 || d3 !== 64'd0 || s3 !== 16'(i)) begin
                failures++; $display("FAIL midrst_hold_%0d got held=%b d=%h stall=%0d exp held=1 d=0 stall=%0d", i, h3, d3, s3, i);
            end
        end
        tick();
        $display("midrst: edge=4 out=%h forced=%b", d3, f3);
        checks++; if (d3 !== 64'h40 || f3 !== 1'b1 || h3 !== 1'b0) begin
            failures++; $display("FAIL midrst_force got d=%h forced=%b held=%b exp 40/1/0", d3, f3, h3);
        end
        hold = 1'b0;
    endtask

    task automatic test_saturation();
        int bad = 0;
        logic [15:0] at_fffe = 16'd0;
        do_reset();
        in_valid = 1'b1; in_data = 64'h55; tick();
        hold = 1'b1; in_data = 64'h66;
        for (int i = 1; i <= 65540; i++) begin
            tick();
            if (d0 !== 64'h55 || h0 !== 1'b1) bad++;
            if (i == 65534) at_fffe = s0;
        end
        $display("saturation: out=%h held=%b stall=%h bad_edges=%0d", d0, h0, s0, bad);
        checks++; if (bad !== 0) begin failures++; $display("FAIL sat_unchanged got bad_edges=%0d exp=0", bad); end
        checks++; if (at_fffe !== 16'hFFFE) begin failures++; $display("FAIL sat_count_mid got=%h exp=fffe", at_fffe); end
        checks++; if (s0 !== 16'hFFFF) begin failures++; $display("FAIL sat_count got=%h exp=ffff", s0); end
        checks++; if (f0 !== 1'b0) begin failures++; $display("FAIL sat_forced got=%b exp=0", f0); end
        hold = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        test_reset();
        test_pipelining();
        test_legacy_hold1();
        test_bounded_hold3();
        test_flush_priority();
        test_reset_mid_stall();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised inter-stage pipeline register that generalises the IF/ID latch to any stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB. It latches a WIDTH-bit payload plus a valid bit and supports three controls:

- **hold**, bounded by a configurable maximum number of consecutive stall cycles;
- **flush**, which inserts a bubble;
- a saturating stall counter for performance monitoring.

It sits between two pipeline stages and is driven by the hazard unit.

## Interface

Parameters:

- WIDTH, 64: payload width in bits (e.g. {PC, instruction} for IF/ID).
- HOLD_MAX, 1: maximum consecutive cycles a hold is honoured before a forced advance. 0 means unlimited.
- NOP_VALUE, 0: payload loaded on reset and on flush (bubble).
- CNT_W, 4: width of the internal consecutive-hold counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- in_data  in  WIDTH  payload from the upstream stage.
- in_valid  in  1  upstream payload is a real instruction.
- hold  in  1  stall request from the hazard unit.
- flush  in  1  squash request; discards the current contents.
- out_data  out  WIDTH  registered payload to the downstream stage.
- out_valid  out  1  registered valid.
- held  out  1  registered; 1 if the previous edge kept contents because of hold.
- forced  out  1  registered; 1 if the previous edge advanced despite hold (HOLD_MAX reached).
- stall_total  out  16  saturating count of held edges since reset.

## Operation

Evaluation happens at each rising edge of clk, in strict priority order. Internal state is hcnt[CNT_W-1:0], the count of consecutive honoured holds.

1. **Reset** (!rst_n):
   - out_data=NOP_VALUE, out_valid=0.
   - hcnt=0, held=0, forced=0, stall_total=0.
2. **Flush** (flush=1):
   - out_data=NOP_VALUE, out_valid=0, hcnt=0, held=0, forced=0.
   - Flush overrides hold. It does not increment stall_total.
3. **Hold honoured** (hold=1 and (HOLD_MAX==0 or hcnt<HOLD_MAX)):
   - out_data and out_valid unchanged.
   - hcnt+1, held=1, forced=0.
   - stall_total+1, saturating at 16'hFFFF.
   - With HOLD_MAX==0, hcnt saturates at all-ones and is not used.
4. **Advance**:
   - out_data=in_data, out_valid=in_valid, hcnt=0, held=0.
   - forced=hold, which is 1 only when hold was asserted but the limit was reached.

Further rules:

- After a forced advance hcnt is 0. If hold stays high, the next edge is honoured again. With HOLD_MAX=1 this gives the alternating hold/advance pattern of the original IF/ID latch.
- in_valid=0 with advance loads in_data as-is. Payload is don't-care when out_valid=0.
- The block contains no combinational path from inputs to outputs.

## Timing

- Latency: 1 cycle from in_data to out_data on an advance edge.
- All outputs change only on the rising edge of clk.
- Reset is synchronous. Asserting rst_n=0 mid-hold clears hcnt, so no stale hold credit survives. The first edge with rst_n=1 evaluates normally.
- Simultaneous hold and flush: flush wins, with held=0 and stall_total unchanged.
- Simultaneous reset and flush: reset wins. The only difference is that stall_total is cleared.
- hold and flush are sampled only at the edge. Glitches between edges have no effect.
- stall_total at 16'hFFFF stays at 16'hFFFF on further honoured holds.
- Max consecutive held edges equals HOLD_MAX (HOLD_MAX≥1). The edge after that is always an advance or a flush.

## Test plan

- **Reset:** WIDTH=64, NOP_VALUE=0, drive rst_n=0 for 2 edges with in_data=64'hDEAD_BEEF_0000_0004 -> out_data=0, out_valid=0, held=0, forced=0, stall_total=0.
- **Plain pipelining:** feed in_data=1,2,3 with in_valid=1 on consecutive edges, hold=flush=0 -> out_data=1,2,3 one edge later each, out_valid=1.
- **HOLD_MAX=1 legacy pattern:** out_data=5; hold=1 for 4 edges with in_data=6,7,8,9 -> 5 (held=1), 7 (forced=1), 7 (held=1), 9 (forced=1); stall_total=2.
- **HOLD_MAX=3 bounded stall:** out_data=A; hold=1 for 5 edges, in_data=B constant -> A held for 3 edges (stall_total=3), 4th edge loads B with forced=1, 5th edge held again.
- **Flush priority:** out_data=0x10, out_valid=1; hold=1 and flush=1 on the same edge -> out_data=NOP_VALUE, out_valid=0, held=0, stall_total unchanged. Next edge hold=0, in_data=0x20 -> out_data=0x20.
- **Reset mid-stall and saturation:** HOLD_MAX=3, after 2 honoured holds assert rst_n=0 for 1 edge, then hold=1 -> 3 more honoured holds before forcing. Separately, with HOLD_MAX=0, hold for 65540 edges -> stall_total=16'hFFFF and out_data unchanged throughout.
